// File: rtl/lock_controller.sv
// Supervisory controller for the keypad digital lock.
// Collects code digits and compares each complete entry with the stored code.
// Counts consecutive failed entries and runs the unlock and lockout windows.
// The stored code can be re-programmed while the lock is open.
// All timing is counted in 1 Hz tick enables.
module lock_controller #(
  parameter int                  CODE_LEN     = 5,
  parameter logic [CODE_LEN-1:0] DEFAULT_CODE = 5'b11011,
  parameter int                  MAX_FAIL     = 3,
  parameter int                  UNLOCK_SEC   = 5,
  parameter int                  LOCKOUT_SEC  = 10,
  parameter int                  ENTRY_TO_SEC = 4
) (
  input  logic       clk_100Mhz,
  input  logic       reset,
  input  logic       tick_1hz,
  input  logic       dig0,
  input  logic       dig1,
  input  logic       prog_req,
  output logic       unlocked,
  output logic       locked_out,
  output logic       prog_mode,
  output logic [1:0] fail_cnt,
  output logic [2:0] digit_cnt,
  output logic [2:0] state_code
);

  // One shared second counter serves every window, so size it for the longest.
  localparam int TMAX  = (UNLOCK_SEC > LOCKOUT_SEC)
                         ? ((UNLOCK_SEC > ENTRY_TO_SEC) ? UNLOCK_SEC : ENTRY_TO_SEC)
                         : ((LOCKOUT_SEC > ENTRY_TO_SEC) ? LOCKOUT_SEC : ENTRY_TO_SEC);
  localparam int TMR_W = $clog2(TMAX + 1);

  typedef enum logic [2:0] {
    ST_ENTRY   = 3'd0,
    ST_EVAL    = 3'd1,
    ST_UNLOCK  = 3'd2,
    ST_PROGRAM = 3'd3,
    ST_LOCKOUT = 3'd4
  } state_e;

  state_e              state_q, state_d;
  logic [CODE_LEN-1:0] code_q, code_d;
  logic [CODE_LEN-1:0] shift_q, shift_d;
  logic [2:0]          digit_cnt_q, digit_cnt_d;
  logic [1:0]          fail_cnt_q, fail_cnt_d;
  logic [TMR_W-1:0]    timer_q, timer_d;
  logic                unlocked_q, locked_out_q, prog_mode_q;

  logic                digit_vld;
  logic [CODE_LEN-1:0] shift_nx;
  logic [2:0]          cnt_inc;
  logic [1:0]          fail_inc;
  logic [TMR_W-1:0]    tmr_inc;

  // Next-state, digit capture, failure counting and window timing.
  always_comb begin
    digit_vld   = dig0 ^ dig1;
    shift_nx    = {shift_q[CODE_LEN-2:0], dig1};
    cnt_inc     = digit_cnt_q + 3'd1;
    fail_inc    = fail_cnt_q + 2'd1;
    tmr_inc     = timer_q + TMR_W'(1);
    state_d     = state_q;
    code_d      = code_q;
    shift_d     = shift_q;
    digit_cnt_d = digit_cnt_q;
    fail_cnt_d  = fail_cnt_q;
    timer_d     = timer_q;
    case (state_q)
      ST_ENTRY: begin
        if (digit_vld) begin
          shift_d     = shift_nx;
          digit_cnt_d = cnt_inc;
          timer_d     = '0;
          if (cnt_inc == 3'(CODE_LEN)) state_d = ST_EVAL;
        end else if (tick_1hz && (digit_cnt_q != 3'd0)) begin
          if (tmr_inc == TMR_W'(ENTRY_TO_SEC)) begin
            digit_cnt_d = 3'd0;
            timer_d     = '0;
          end else begin
            timer_d = tmr_inc;
          end
        end
      end
      ST_EVAL: begin
        digit_cnt_d = 3'd0;
        timer_d     = '0;
        if (shift_q == code_q) begin
          fail_cnt_d = 2'd0;
          state_d    = ST_UNLOCK;
        end else begin
          fail_cnt_d = fail_inc;
          state_d    = (fail_inc == 2'(MAX_FAIL)) ? ST_LOCKOUT : ST_ENTRY;
        end
      end
      ST_UNLOCK: begin
        if (prog_req) begin
          state_d = ST_PROGRAM;
          timer_d = '0;
        end else if (tick_1hz) begin
          if (tmr_inc == TMR_W'(UNLOCK_SEC)) begin
            state_d = ST_ENTRY;
            timer_d = '0;
          end else begin
            timer_d = tmr_inc;
          end
        end
      end
      ST_PROGRAM: begin
        // Idle ticks count here even before the first digit so PROGRAM cannot stall.
        if (digit_vld) begin
          shift_d     = shift_nx;
          digit_cnt_d = cnt_inc;
          timer_d     = '0;
          if (cnt_inc == 3'(CODE_LEN)) begin
            code_d      = shift_nx;
            fail_cnt_d  = 2'd0;
            digit_cnt_d = 3'd0;
            state_d     = ST_ENTRY;
          end
        end else if (tick_1hz) begin
          if (tmr_inc == TMR_W'(ENTRY_TO_SEC)) begin
            digit_cnt_d = 3'd0;
            timer_d     = '0;
            state_d     = ST_ENTRY;
          end else begin
            timer_d = tmr_inc;
          end
        end
      end
      ST_LOCKOUT: begin
        if (tick_1hz) begin
          if (tmr_inc == TMR_W'(LOCKOUT_SEC)) begin
            fail_cnt_d = 2'd0;
            timer_d    = '0;
            state_d    = ST_ENTRY;
          end else begin
            timer_d = tmr_inc;
          end
        end
      end
      default: begin
        state_d     = ST_ENTRY;
        digit_cnt_d = 3'd0;
        fail_cnt_d  = 2'd0;
        timer_d     = '0;
      end
    endcase
  end

  // State, code, counters and registered status flags; reset wins over everything.
  always_ff @(posedge clk_100Mhz) begin
    if (reset) begin
      state_q      <= ST_ENTRY;
      code_q       <= DEFAULT_CODE;
      shift_q      <= '0;
      digit_cnt_q  <= 3'd0;
      fail_cnt_q   <= 2'd0;
      timer_q      <= '0;
      unlocked_q   <= 1'b0;
      locked_out_q <= 1'b0;
      prog_mode_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      code_q       <= code_d;
      shift_q      <= shift_d;
      digit_cnt_q  <= digit_cnt_d;
      fail_cnt_q   <= fail_cnt_d;
      timer_q      <= timer_d;
      unlocked_q   <= (state_d == ST_UNLOCK);
      locked_out_q <= (state_d == ST_LOCKOUT);
      prog_mode_q  <= (state_d == ST_PROGRAM);
    end
  end

  assign unlocked   = unlocked_q;
  assign locked_out = locked_out_q;
  assign prog_mode  = prog_mode_q;
  assign fail_cnt   = fail_cnt_q;
  assign digit_cnt  = digit_cnt_q;
  assign state_code = state_q;

endmodule

// File: tb/tb_lock_controller.sv
// Bench for lock_controller: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a behavioural model.
module tb_lock_controller;

  localparam int CODE_LEN     = 5;
  localparam int MAX_FAIL     = 3;
  localparam int UNLOCK_SEC   = 5;
  localparam int LOCKOUT_SEC  = 10;
  localparam int ENTRY_TO_SEC = 4;
  localparam int DEFAULT_CODE = 27;  // 11011

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       tick = 1'b0;
  logic       dig0 = 1'b0;
  logic       dig1 = 1'b0;
  logic       prog_req = 1'b0;
  logic       unlocked, locked_out, prog_mode;
  logic [1:0] fail_cnt;
  logic [2:0] digit_cnt, state_code;

  always #5 clk = ~clk;

  lock_controller dut (
    .clk_100Mhz (clk),
    .reset      (reset),
    .tick_1hz   (tick),
    .dig0       (dig0),
    .dig1       (dig1),
    .prog_req   (prog_req),
    .unlocked   (unlocked),
    .locked_out (locked_out),
    .prog_mode  (prog_mode),
    .fail_cnt   (fail_cnt),
    .digit_cnt  (digit_cnt),
    .state_code (state_code)
  );

  int vectors = 0;
  int miscompares = 0;

  // Behavioural model: mode number as published on state_code, digits kept as a queue.
  int m_mode = 0;
  bit m_digits[$];
  int m_code = DEFAULT_CODE;
  int m_fails = 0;
  int m_secs = 0;
  int m_idle = 0;
  bit m_ok = 1'b0;

  always @(posedge clk) begin : model
    bit v;
    int val;
    v = dig0 ^ dig1;
    val = 0;
    if (reset) begin
      m_mode = 0; m_digits.delete(); m_code = DEFAULT_CODE;
      m_fails = 0; m_secs = 0; m_idle = 0; m_ok = 1'b1;
    end else if (m_ok) begin
      case (m_mode)
        0: begin
          if (v) begin
            m_digits.push_back(dig1); m_idle = 0;
            if (m_digits.size() == CODE_LEN) m_mode = 1;
          end else if (tick && m_digits.size() != 0) begin
            m_idle++;
            if (m_idle == ENTRY_TO_SEC) begin m_digits.delete(); m_idle = 0; end
          end
        end
        1: begin
          foreach (m_digits[i]) val = val * 2 + int'(m_digits[i]);
          m_digits.delete(); m_secs = 0; m_idle = 0;
          if (val == m_code) begin
            m_fails = 0; m_mode = 2;
          end else begin
            m_fails++;
            m_mode = (m_fails == MAX_FAIL) ? 4 : 0;
          end
        end
        2: begin
          if (prog_req) begin
            m_mode = 3; m_secs = 0; m_idle = 0;
          end else if (tick) begin
            m_secs++;
            if (m_secs == UNLOCK_SEC) begin m_mode = 0; m_secs = 0; end
          end
        end
        3: begin
          if (v) begin
            m_digits.push_back(dig1); m_idle = 0;
            if (m_digits.size() == CODE_LEN) begin
              foreach (m_digits[i]) val = val * 2 + int'(m_digits[i]);
              m_code = val; m_digits.delete(); m_fails = 0; m_mode = 0;
            end
          end else if (tick) begin
            m_idle++;
            if (m_idle == ENTRY_TO_SEC) begin m_digits.delete(); m_idle = 0; m_mode = 0; end
          end
        end
        4: begin
          if (tick) begin
            m_secs++;
            if (m_secs == LOCKOUT_SEC) begin m_mode = 0; m_fails = 0; m_secs = 0; end
          end
        end
        default: m_mode = 0;
      endcase
    end
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin : compare
    logic [10:0] act, exp;
    if (m_ok) begin
      exp = {m_mode == 2, m_mode == 4, m_mode == 3, 2'(m_fails),
             3'(m_digits.size()), 3'(m_mode)};
      act = {unlocked, locked_out, prog_mode, fail_cnt, digit_cnt, state_code};
      vectors++;
      if (act !== exp) begin
        miscompares++;
        $display("FAIL model_cmp t=%0t actual=%b expected=%b (unl,lko,prg,fail,dig,state)",
                 $time, act, exp);
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  task automatic step(input logic d0, input logic d1, input logic tk,
                      input logic pr, input logic rs);
    @(negedge clk);
    dig0 = d0; dig1 = d1; tick = tk; prog_req = pr; reset = rs;
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic ticks(input int n);
    repeat (n) step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  // Pulses CODE_LEN digits MSB first, then one quiet cycle.
  task automatic enter(input int val);
    bit b;
    for (int i = CODE_LEN - 1; i >= 0; i--) begin
      b = val[i];
      step(!b, b, 1'b0, 1'b0, 1'b0);
    end
    idle(1);
  endtask

  initial begin : stim
    int r;
    int k;
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(1);
    chk("rst_state", state_code, 0);
    chk("rst_fail", fail_cnt, 0);
    chk("rst_digits", digit_cnt, 0);
    chk("rst_unlocked", unlocked, 0);

    // Correct default code unlocks two edges after the last pulse, closes after 5 ticks.
    enter(27);
    chk("eval_state", state_code, 1);
    chk("eval_digits", digit_cnt, 5);
    chk("eval_unlocked", unlocked, 0);
    idle(1);
    chk("unlock_rise", unlocked, 1);
    chk("unlock_state", state_code, 2);
    chk("model_pin_unlock", m_mode, 2);
    ticks(4); idle(1);
    chk("unlock_hold", unlocked, 1);
    ticks(1); idle(1);
    chk("unlock_expire", unlocked, 0);
    chk("unlock_exp_state", state_code, 0);

    // Three wrong entries lock out; digits and prog_req ignored; 10 ticks release.
    enter(0); idle(1);
    chk("fail_1", fail_cnt, 1);
    chk("fail_1_state", state_code, 0);
    enter(0); idle(1);
    chk("fail_2", fail_cnt, 2);
    enter(0); idle(1);
    chk("lockout_flag", locked_out, 1);
    chk("lockout_state", state_code, 4);
    chk("model_pin_fails", m_fails, 3);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(1);
    chk("lockout_digits", digit_cnt, 0);
    chk("lockout_prog", prog_mode, 0);
    ticks(9); idle(1);
    chk("lockout_hold", state_code, 4);
    ticks(1); idle(1);
    chk("lockout_exit_state", state_code, 0);
    chk("lockout_exit_fail", fail_cnt, 0);
    chk("lockout_exit_flag", locked_out, 0);

    // Programming a new code, old code rejected, new code accepted.
    enter(27); idle(1);
    chk("prog_pre_unlock", unlocked, 1);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0); idle(1);
    chk("prog_mode", prog_mode, 1);
    chk("prog_state", state_code, 3);
    enter(21);
    chk("prog_done_state", state_code, 0);
    chk("prog_done_flag", prog_mode, 0);
    enter(27); idle(1);
    chk("old_code_fail", fail_cnt, 1);
    chk("model_pin_code", m_code, 21);
    enter(21); idle(1);
    chk("new_code_unlock", unlocked, 1);
    chk("new_code_fail_clr", fail_cnt, 0);
    // prog_req beats a same-cycle final tick; PROGRAM then times out.
    ticks(4);
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0); idle(1);
    chk("prog_over_expiry", state_code, 3);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    ticks(3); idle(1);
    chk("prog_to_hold", state_code, 3);
    chk("prog_to_digits", digit_cnt, 1);
    ticks(1); idle(1);
    chk("prog_to_exit", state_code, 0);
    chk("prog_to_digclr", digit_cnt, 0);
    enter(21); idle(1);
    chk("code_kept_after_abort", unlocked, 1);
    ticks(5); idle(1);
    chk("unlock_expire2", state_code, 0);

    // Simultaneous digits ignored; partial entry abandoned after 4 idle ticks.
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0); idle(1);
    chk("both_digits_ignored", digit_cnt, 0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0); idle(1);
    chk("partial_digits", digit_cnt, 2);
    ticks(3); idle(1);
    chk("partial_hold", digit_cnt, 2);
    ticks(1); idle(1);
    chk("partial_timeout", digit_cnt, 0);
    chk("partial_fail", fail_cnt, 0);

    // Reset in LOCKOUT and in PROGRAM; default code restored.
    enter(0); enter(0); enter(0); idle(1);
    chk("lockout2_state", state_code, 4);
    ticks(3);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1); idle(1);
    chk("rst_lockout_state", state_code, 0);
    chk("rst_lockout_fail", fail_cnt, 0);
    enter(27); idle(1);
    chk("rst_default_unlock", unlocked, 1);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1); idle(1);
    chk("rst_prog_state", state_code, 0);
    chk("rst_prog_fail", fail_cnt, 0);
    chk("rst_prog_flag", prog_mode, 0);
    enter(27); idle(1);
    chk("default_code_after_reset", unlocked, 1);
    ticks(5); idle(1);

    // Randomized traffic, checked every cycle by the compare process.
    for (int it = 0; it < 300; it++) begin
      r = $urandom_range(0, 3);
      case (r)
        0: enter(m_code);
        1: enter($urandom_range(0, 31));
        2: repeat ($urandom_range(4, 16)) begin
             k = $urandom_range(0, 99);
             step(k < 15, (k >= 10) && (k < 25), $urandom_range(0, 3) == 0,
                  $urandom_range(0, 19) == 0, $urandom_range(0, 399) == 0);
           end
        default: begin
          step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
          enter($urandom_range(0, 31));
        end
      endcase
    end
    idle(2);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
